rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 84 ++++++++
 tb/tb_rf_wb_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU (A) and load (B) writebacks,
// one registered RF write per cycle, plus a pending-write scoreboard for hazard checks.
module rf_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] rf_Rd,
  output logic [DATA_W-1:0] rf_data_write,
  output logic              rf_reg_wr,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] chk_Rn,
  input  logic [ADDR_W-1:0] chk_Rm,
  output logic              hazard_Rn,
  output logic              hazard_Rm
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] XZR = '1;

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  ptr_e             ptr;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // The pointer only matters when both requesters are valid; nothing is granted during reset.
  always_comb begin
    a_ready = rst_n && a_valid && (!b_valid || (ptr == PTR_A));
    b_ready = rst_n && b_valid && (!a_valid || (ptr == PTR_B));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= PTR_A;
    else if (a_ready) ptr <= PTR_B;
    else if (b_ready) ptr <= PTR_A;
  end

  // Writes to XZR are accepted and latched but never enabled towards the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_wr     <= 1'b0;
      rf_Rd         <= '0;
      rf_data_write <= '0;
    end else if (a_ready) begin
      rf_reg_wr     <= (a_rd != XZR);
      rf_Rd         <= a_rd;
      rf_data_write <= a_data;
    end else if (b_ready) begin
      rf_reg_wr     <= (b_rd != XZR);
      rf_Rd         <= b_rd;
      rf_data_write <= b_data;
    end else begin
      rf_reg_wr     <= 1'b0;
    end
  end

  // A new issue to the same register overrides the commit happening at the same edge.
  always_comb begin
    busy_next = busy;
    if (rf_reg_wr) busy_next[rf_Rd] = 1'b0;
    if (issue_valid && (issue_rd != XZR)) busy_next[issue_rd] = 1'b1;
    busy_next[XZR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign hazard_Rn = busy[chk_Rn];
  assign hazard_Rm = busy[chk_Rm];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a reference model predicts grants, hazards and the
// registered RF write; predicted writes are queued and popped one cycle later for comparison.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd, chk_Rn, chk_Rm;
  logic [63:0] a_data, b_data;
  logic        a_ready, b_ready, rf_reg_wr, hazard_Rn, hazard_Rm;
  logic [4:0]  rf_Rd;
  logic [63:0] rf_data_write;

  typedef struct packed {
    logic        wr;
    logic        known;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t        expq[$];
  logic        m_ptr;
  logic [31:0] m_busy;
  logic        ga, gb;
  int          n_checks;
  int          n_fail;

  logic        pa_v, pb_v;
  logic [4:0]  pa_rd, pb_rd;
  logic [63:0] pa_d, pb_d;

  rf_wb_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_Rd(rf_Rd), .rf_data_write(rf_data_write), .rf_reg_wr(rf_reg_wr),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_Rn(chk_Rn), .chk_Rm(chk_Rm),
    .hazard_Rn(hazard_Rn), .hazard_Rm(hazard_Rm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic resetModel();
    exp_t e;
    e = '0;
    e.known = 1'b1;
    expq.delete();
    expq.push_back(e);
    m_ptr  = 1'b0;
    m_busy = '0;
  endtask

  // Called just after a rising edge; checks at the falling edge, then advances the model.
  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                               input logic bv, input logic [4:0] brd, input logic [63:0] bd,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] crn, input logic [4:0] crm);
    exp_t cur, nxt;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    issue_valid = iv; issue_rd = ird;
    chk_Rn = crn; chk_Rm = crm;
    @(negedge clk);
    if (expq.size() == 0) begin
      checkOutput("queue_empty", 64'd1, 64'd0);
      cur = '0;
    end else begin
      cur = expq.pop_front();
    end
    checkOutput("rf_reg_wr", {63'd0, rf_reg_wr}, {63'd0, cur.wr});
    if (cur.known) begin
      checkOutput("rf_Rd", {59'd0, rf_Rd}, {59'd0, cur.rd});
      checkOutput("rf_data_write", rf_data_write, cur.data);
    end
    ga = av && (!bv || !m_ptr);
    gb = bv && (!av || m_ptr);
    checkOutput("a_ready", {63'd0, a_ready}, {63'd0, ga});
    checkOutput("b_ready", {63'd0, b_ready}, {63'd0, gb});
    checkOutput("hazard_Rn", {63'd0, hazard_Rn}, {63'd0, m_busy[crn]});
    checkOutput("hazard_Rm", {63'd0, hazard_Rm}, {63'd0, m_busy[crm]});
    nxt = cur;
    nxt.wr = 1'b0;
    if (ga) begin
      nxt.wr = (ard != 5'd31); nxt.known = (ard != 5'd31); nxt.rd = ard; nxt.data = ad;
    end else if (gb) begin
      nxt.wr = (brd != 5'd31); nxt.known = (brd != 5'd31); nxt.rd = brd; nxt.data = bd;
    end
    expq.push_back(nxt);
    if (ga)      m_ptr = 1'b1;
    else if (gb) m_ptr = 1'b0;
    if (cur.wr) m_busy[cur.rd] = 1'b0;
    if (iv && (ird != 5'd31)) m_busy[ird] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] crn);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, crn, 5'd31);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 1; b_rd = 0; b_data = 0;
    issue_valid = 0; issue_rd = 0; chk_Rn = 0; chk_Rm = 31;
    #2;
    checkOutput("init_rf_reg_wr", {63'd0, rf_reg_wr}, 64'd0);
    checkOutput("init_rf_Rd", {59'd0, rf_Rd}, 64'd0);
    checkOutput("init_rf_data", rf_data_write, 64'd0);
    checkOutput("init_b_ready", {63'd0, b_ready}, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    resetModel();

    // Both valid continuously: A,B,A,B
    for (int i = 0; i < 4; i++) applyStimulus(1, 5'd1, 64'hA1, 1, 5'd2, 64'hB2, 0, 0, 0, 31);
    idle(0);
    idle(0);

    // Single A write, then idles to see the pulse and the hold
    applyStimulus(1, 5'd3, 64'h55, 0, 0, 0, 0, 0, 0, 31);
    idle(0);
    idle(0);

    // B to XZR: accepted, never written, no scoreboard effect
    applyStimulus(0, 0, 0, 1, 5'd31, 64'hFF, 1, 5'd31, 5'd31, 5'd31);
    idle(31);
    idle(31);

    // Hazard lifecycle on x5, including a same-edge reissue
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd31);
    applyStimulus(1, 5'd5, 64'h1234, 0, 0, 0, 0, 0, 5'd5, 5'd31);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd31);
    applyStimulus(0, 0, 0, 1, 5'd5, 64'h5678, 0, 0, 5'd5, 5'd31);
    idle(5);
    idle(5);

    // Same rd from both requesters: two separate ordered writes
    applyStimulus(1, 5'd9, 64'h900A, 1, 5'd9, 64'h900B, 1, 5'd9, 5'd9, 5'd5);
    applyStimulus(1, 5'd9, 64'h900A, 0, 0, 0, 0, 0, 5'd9, 5'd5);
    idle(9);
    idle(9);

    // Randomised traffic; requesters hold their request until granted
    pa_v = 0; pb_v = 0; pa_rd = 0; pb_rd = 0; pa_d = 0; pb_d = 0;
    for (int i = 0; i < 40; i++) begin
      if (!pa_v && ($urandom_range(0, 2) != 0)) begin
        pa_v = 1; pa_rd = 5'($urandom_range(0, 31)); pa_d = {$urandom, $urandom};
      end
      if (!pb_v && ($urandom_range(0, 2) != 0)) begin
        pb_v = 1; pb_rd = 5'($urandom_range(0, 31)); pb_d = {$urandom, $urandom};
      end
      applyStimulus(pa_v, pa_rd, pa_d, pb_v, pb_rd, pb_d,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (ga) pa_v = 0;
      if (gb) pb_v = 0;
    end
    for (int i = 0; i < 3; i++) idle(0);

    // Mid-cycle reset while a write to x7 is in flight and x7 is busy
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd31);
    applyStimulus(0, 0, 0, 1, 5'd8, 64'h88, 0, 0, 5'd7, 5'd31);
    applyStimulus(1, 5'd7, 64'h77, 0, 0, 0, 0, 0, 5'd7, 5'd31);
    checkOutput("pre_rst_rf_reg_wr", {63'd0, rf_reg_wr}, 64'd1);
    checkOutput("pre_rst_hazard", {63'd0, hazard_Rn}, 64'd1);
    #2;
    rst_n = 1'b0;
    a_valid = 1; b_valid = 1; issue_valid = 1; issue_rd = 5'd9;
    #1;
    checkOutput("rst_rf_reg_wr", {63'd0, rf_reg_wr}, 64'd0);
    checkOutput("rst_rf_Rd", {59'd0, rf_Rd}, 64'd0);
    checkOutput("rst_rf_data", rf_data_write, 64'd0);
    checkOutput("rst_hazard_Rn", {63'd0, hazard_Rn}, 64'd0);
    checkOutput("rst_a_ready", {63'd0, a_ready}, 64'd0);
    checkOutput("rst_b_ready", {63'd0, b_ready}, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    resetModel();
    applyStimulus(1, 5'd4, 64'h44, 1, 5'd6, 64'h66, 0, 0, 5'd9, 5'd7);
    applyStimulus(0, 0, 0, 1, 5'd6, 64'h66, 0, 0, 5'd9, 5'd7);
    idle(0);
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
